// File: rtl/wback_pipe_if.sv
// Memory-stage to write-back bundle: me_* carry the instruction in, wb_* are
// pipeline controls, wr_* are the registered write-back results.
interface wback_pipe_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  localparam int OFS_W = $clog2(DATA_W / 8);

  logic              me_Valid;
  logic [DATA_W-1:0] me_ExtMemRdData;
  logic [DATA_W-1:0] me_ByData;
  logic              me_MemRegSel;
  logic [1:0]        me_LdSize;
  logic              me_LdSigned;
  logic [OFS_W-1:0]  me_ByteOfs;
  logic              me_RegWriteSel;
  logic [REG_AW-1:0] me_RegDest;
  logic              wb_Stall;
  logic              wb_Flush;
  logic [REG_AW-1:0] wr_RegDest;
  logic [DATA_W-1:0] wr_Data;
  logic              wr_RegWriteSel;
  logic              wr_Valid;
  logic              wr_AlignErr;

  modport master (
    output me_Valid, me_ExtMemRdData, me_ByData, me_MemRegSel, me_LdSize,
           me_LdSigned, me_ByteOfs, me_RegWriteSel, me_RegDest,
           wb_Stall, wb_Flush,
    input  wr_RegDest, wr_Data, wr_RegWriteSel, wr_Valid, wr_AlignErr
  );

  modport slave (
    input  me_Valid, me_ExtMemRdData, me_ByData, me_MemRegSel, me_LdSize,
           me_LdSigned, me_ByteOfs, me_RegWriteSel, me_RegDest,
           wb_Stall, wb_Flush,
    output wr_RegDest, wr_Data, wr_RegWriteSel, wr_Valid, wr_AlignErr
  );
endinterface

// File: rtl/wback_pipe.sv
// Write-back pipeline register: extracts and extends load data, flags
// misaligned loads and holds/flushes under pipeline control.
module wback_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic        clk,
  input logic        reset,
  wback_pipe_if.slave bus
);
  localparam int OFS_W = $clog2(DATA_W / 8);

  generate
    if (DATA_W != 32 && DATA_W != 64) begin : g_badWidth
      $error("wback_pipe: DATA_W must be 32 or 64");
    end
  endgenerate

  logic [OFS_W-1:0]  w_ofs;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_wordExt;
  logic [DATA_W-1:0] w_ext;
  logic [DATA_W-1:0] w_data;
  logic              w_misalign;
  logic              w_valid;
  logic              w_regWrite;

  logic [REG_AW-1:0] r_regDest;
  logic [DATA_W-1:0] r_data;
  logic              r_regWriteSel;
  logic              r_valid;
  logic              r_alignErr;

  assign w_ofs     = bus.me_ByteOfs;
  assign w_shifted = bus.me_ExtMemRdData >> {w_ofs, 3'b000};

  // A word is only a narrower lane on the 64-bit datapath.
  generate
    if (DATA_W == 64) begin : g_word64
      assign w_wordExt = {{(DATA_W-32){bus.me_LdSigned & w_shifted[31]}}, w_shifted[31:0]};
    end else begin : g_word32
      assign w_wordExt = w_shifted;
    end
  endgenerate

  always_comb begin
    w_ext = w_shifted;
    case (bus.me_LdSize)
      2'b00:   w_ext = {{(DATA_W-8){bus.me_LdSigned & w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_ext = {{(DATA_W-16){bus.me_LdSigned & w_shifted[15]}}, w_shifted[15:0]};
      2'b10:   w_ext = w_wordExt;
      default: w_ext = w_shifted;
    endcase
  end

  // On 32 bits the dword encoding reduces to a word check, since |w_ofs covers it.
  always_comb begin
    w_misalign = 1'b0;
    if (bus.me_MemRegSel) begin
      case (bus.me_LdSize)
        2'b00:   w_misalign = 1'b0;
        2'b01:   w_misalign = w_ofs[0];
        2'b10:   w_misalign = |w_ofs[1:0];
        default: w_misalign = |w_ofs;
      endcase
    end
  end

  assign w_data     = bus.me_MemRegSel ? w_ext : bus.me_ByData;
  assign w_valid    = bus.me_Valid & ~bus.wb_Flush;
  assign w_regWrite = bus.me_RegWriteSel & w_valid & ~w_misalign & (|bus.me_RegDest);

  // Flush wins over stall; a stalled flush clears only the status bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regDest     <= '0;
      r_data        <= '0;
      r_regWriteSel <= 1'b0;
      r_valid       <= 1'b0;
      r_alignErr    <= 1'b0;
    end else if (!bus.wb_Stall) begin
      r_regDest     <= bus.me_RegDest;
      r_data        <= w_data;
      r_regWriteSel <= w_regWrite;
      r_valid       <= w_valid;
      r_alignErr    <= w_valid & w_misalign;
    end else if (bus.wb_Flush) begin
      r_regWriteSel <= 1'b0;
      r_valid       <= 1'b0;
      r_alignErr    <= 1'b0;
    end
  end

  assign bus.wr_RegDest     = r_regDest;
  assign bus.wr_Data        = r_data;
  assign bus.wr_RegWriteSel = r_regWriteSel;
  assign bus.wr_Valid       = r_valid;
  assign bus.wr_AlignErr    = r_alignErr;
endmodule

// File: tb/tb_wback_pipe.sv
// Self-checking bench for wback_pipe: 32-bit vector table through a
// scoreboard, stall/flush/reset sequences, and a 64-bit instance.
module tb_wback_pipe;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] RD32 = 32'h80FF7F01;
  localparam logic [63:0] RD64 = 64'h80000000_12345678;

  wback_pipe_if #(.DATA_W(32), .REG_AW(5)) bus32 ();
  wback_pipe_if #(.DATA_W(64), .REG_AW(5)) bus64 ();

  wback_pipe #(.DATA_W(32), .REG_AW(5)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
  wback_pipe #(.DATA_W(64), .REG_AW(5)) dut64 (.clk(clk), .reset(reset), .bus(bus64.slave));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic        memSel;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  ofs;
    logic        ws;
    logic [4:0]  dest;
    logic [31:0] by;
    logic        flush;
    logic        eValid;
    logic        eWe;
    logic        eErr;
    logic        chkData;
    logic [31:0] eData;
  } vec_t;

  typedef struct {
    string       name;
    logic        eValid;
    logic        eWe;
    logic        eErr;
    logic        chkData;
    logic [4:0]  eDest;
    logic [31:0] eData;
  } exp_t;

  vec_t vecs[16];
  exp_t sbQ[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkState32(input string tag, input logic v, input logic we, input logic err,
                              input logic [4:0] dest, input logic [31:0] data);
    checkOutput({tag, ".valid"}, {63'd0, bus32.wr_Valid}, {63'd0, v});
    checkOutput({tag, ".we"},    {63'd0, bus32.wr_RegWriteSel}, {63'd0, we});
    checkOutput({tag, ".err"},   {63'd0, bus32.wr_AlignErr}, {63'd0, err});
    checkOutput({tag, ".dest"},  {59'd0, bus32.wr_RegDest}, {59'd0, dest});
    checkOutput({tag, ".data"},  {32'd0, bus32.wr_Data}, {32'd0, data});
  endtask

  task automatic driveInputs(input vec_t v);
    bus32.me_Valid        = v.valid;
    bus32.me_ExtMemRdData = RD32;
    bus32.me_ByData       = v.by;
    bus32.me_MemRegSel    = v.memSel;
    bus32.me_LdSize       = v.size;
    bus32.me_LdSigned     = v.sgn;
    bus32.me_ByteOfs      = v.ofs;
    bus32.me_RegWriteSel  = v.ws;
    bus32.me_RegDest      = v.dest;
    bus32.wb_Stall        = 1'b0;
    bus32.wb_Flush        = v.flush;
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    driveInputs(v);
    e.name    = v.name;
    e.eValid  = v.eValid;
    e.eWe     = v.eWe;
    e.eErr    = v.eErr;
    e.chkData = v.chkData;
    e.eDest   = v.dest;
    e.eData   = v.eData;
    sbQ.push_back(e);
  endtask

  task automatic scoreNext();
    exp_t e;
    if (sbQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sbQ.pop_front();
      checkOutput({e.name, ".valid"}, {63'd0, bus32.wr_Valid}, {63'd0, e.eValid});
      checkOutput({e.name, ".we"},    {63'd0, bus32.wr_RegWriteSel}, {63'd0, e.eWe});
      checkOutput({e.name, ".err"},   {63'd0, bus32.wr_AlignErr}, {63'd0, e.eErr});
      checkOutput({e.name, ".dest"},  {59'd0, bus32.wr_RegDest}, {59'd0, e.eDest});
      if (e.chkData)
        checkOutput({e.name, ".data"}, {32'd0, bus32.wr_Data}, {32'd0, e.eData});
    end
  endtask

  task automatic drive64(input logic [1:0] size, input logic sgn, input logic [2:0] ofs);
    bus64.me_Valid        = 1'b1;
    bus64.me_ExtMemRdData = RD64;
    bus64.me_ByData       = 64'd0;
    bus64.me_MemRegSel    = 1'b1;
    bus64.me_LdSize       = size;
    bus64.me_LdSigned     = sgn;
    bus64.me_ByteOfs      = ofs;
    bus64.me_RegWriteSel  = 1'b1;
    bus64.me_RegDest      = 5'd1;
    bus64.wb_Stall        = 1'b0;
    bus64.wb_Flush        = 1'b0;
  endtask

  task automatic run64(input string name, input logic [1:0] size, input logic sgn,
                       input logic [2:0] ofs, input logic err, input logic [63:0] data);
    drive64(size, sgn, ofs);
    @(posedge clk);
    #1;
    checkOutput({name, ".err"}, {63'd0, bus64.wr_AlignErr}, {63'd0, err});
    checkOutput({name, ".we"},  {63'd0, bus64.wr_RegWriteSel}, {63'd0, ~err});
    if (!err) checkOutput({name, ".data"}, bus64.wr_Data, data);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{"lbSigned3",   1,1,2'b00,1,2'd3,1,5'd5, 32'h0,        0, 1,1,0,1,32'hFFFFFF80};
    vecs[1]  = '{"lhuOfs2",     1,1,2'b01,0,2'd2,1,5'd6, 32'h0,        0, 1,1,0,1,32'h000080FF};
    vecs[2]  = '{"lwMis1",      1,1,2'b10,0,2'd1,1,5'd7, 32'h0,        0, 1,0,1,0,32'h0};
    vecs[3]  = '{"aluR0",       1,0,2'b01,1,2'd1,1,5'd0, 32'h12345678, 0, 1,0,0,1,32'h12345678};
    vecs[4]  = '{"lbuOfs1",     1,1,2'b00,0,2'd1,1,5'd3, 32'h0,        0, 1,1,0,1,32'h0000007F};
    vecs[5]  = '{"lbSigned0",   1,1,2'b00,1,2'd0,1,5'd4, 32'h0,        0, 1,1,0,1,32'h00000001};
    vecs[6]  = '{"lhSigned2",   1,1,2'b01,1,2'd2,1,5'd9, 32'h0,        0, 1,1,0,1,32'hFFFF80FF};
    vecs[7]  = '{"lhSigned0",   1,1,2'b01,1,2'd0,1,5'd10,32'h0,        0, 1,1,0,1,32'h00007F01};
    vecs[8]  = '{"lwOfs0",      1,1,2'b10,1,2'd0,1,5'd11,32'h0,        0, 1,1,0,1,32'h80FF7F01};
    vecs[9]  = '{"ldAsWord",    1,1,2'b11,0,2'd0,1,5'd12,32'h0,        0, 1,1,0,1,32'h80FF7F01};
    vecs[10] = '{"ldMis2",      1,1,2'b11,0,2'd2,1,5'd13,32'h0,        0, 1,0,1,0,32'h0};
    vecs[11] = '{"lhMis3",      1,1,2'b01,0,2'd3,1,5'd14,32'h0,        0, 1,0,1,0,32'h0};
    vecs[12] = '{"notValid",    0,1,2'b10,0,2'd1,1,5'd15,32'h0,        0, 0,0,0,0,32'h0};
    vecs[13] = '{"flushed",     1,1,2'b00,1,2'd0,1,5'd16,32'h0,        1, 0,0,0,0,32'h0};
    vecs[14] = '{"noWrite",     1,0,2'b00,0,2'd0,0,5'd8, 32'hCAFEF00D, 0, 1,0,0,1,32'hCAFEF00D};
    vecs[15] = '{"aluNoAlign",  1,0,2'b10,0,2'd3,1,5'd2, 32'hDEADBEEF, 0, 1,1,0,1,32'hDEADBEEF};

    reset = 1'b1;
    driveInputs(vecs[12]);
    bus32.me_Valid = 1'b0;
    drive64(2'b00, 1'b0, 3'd0);
    bus64.me_Valid = 1'b0;
    #1;
    checkState32("reset32", 0, 0, 0, 5'd0, 32'h0);
    checkOutput("reset64.valid", {63'd0, bus64.wr_Valid}, 64'd0);
    checkOutput("reset64.data", bus64.wr_Data, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      scoreNext();
    end

    applyStimulus(vecs[0]);
    @(posedge clk);
    #1;
    scoreNext();
    for (int k = 0; k < 3; k++) begin
      driveInputs(vecs[4 + k]);
      bus32.wb_Stall = 1'b1;
      @(posedge clk);
      #1;
      checkState32("stallHold", 1, 1, 0, 5'd5, 32'hFFFFFF80);
    end
    driveInputs(vecs[1]);
    bus32.wb_Stall = 1'b1;
    bus32.wb_Flush = 1'b1;
    @(posedge clk);
    #1;
    checkState32("stallFlush", 0, 0, 0, 5'd5, 32'hFFFFFF80);

    driveInputs(vecs[2]);
    @(posedge clk);
    #1;
    checkOutput("misCapture.err", {63'd0, bus32.wr_AlignErr}, 64'd1);
    driveInputs(vecs[0]);
    bus32.wb_Stall = 1'b1;
    bus32.wb_Flush = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("misFlush.err", {63'd0, bus32.wr_AlignErr}, 64'd0);
    checkOutput("misFlush.valid", {63'd0, bus32.wr_Valid}, 64'd0);
    checkOutput("misFlush.dest", {59'd0, bus32.wr_RegDest}, 64'd7);

    driveInputs(vecs[0]);
    @(posedge clk);
    #1;
    driveInputs(vecs[5]);
    bus32.wb_Stall = 1'b1;
    @(posedge clk);
    #1;
    checkState32("preReset", 1, 1, 0, 5'd5, 32'hFFFFFF80);
    #2;
    reset = 1'b1;
    #1;
    checkState32("asyncReset", 0, 0, 0, 5'd0, 32'h0);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkState32("resetDiscard", 0, 0, 0, 5'd0, 32'h0);
    applyStimulus(vecs[1]);
    @(posedge clk);
    #1;
    scoreNext();

    run64("w64SignedOfs4",   2'b10, 1'b1, 3'd4, 1'b0, 64'hFFFFFFFF_80000000);
    run64("w64UnsignedOfs4", 2'b10, 1'b0, 3'd4, 1'b0, 64'h00000000_80000000);
    run64("w64SignedOfs0",   2'b10, 1'b1, 3'd0, 1'b0, 64'h00000000_12345678);
    run64("d64Ofs0",         2'b11, 1'b1, 3'd0, 1'b0, 64'h80000000_12345678);
    run64("d64Mis4",         2'b11, 1'b0, 3'd4, 1'b1, 64'h0);
    run64("b64SignedOfs7",   2'b00, 1'b1, 3'd7, 1'b0, 64'hFFFFFFFF_FFFFFF80);
    run64("h64SignedOfs6",   2'b01, 1'b1, 3'd6, 1'b0, 64'hFFFFFFFF_FFFF8000);
    run64("w64Mis2",         2'b10, 1'b1, 3'd2, 1'b1, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
